vga_timing_ctrl: RTL and testbench

//  Generates 640x480@60 VGA timing (800x525 total, 25 MHz pixel clock) from free-running h/v counters.

---
 rtl/vga_timing_ctrl.sv | 90 +++++++++
 tb/tb_vga_timing_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA timing generator (640x480@60 by default).
// Free-running h/v counters produce coordinates to the picture generator.
// Sync outputs are registered one cycle so they line up with the returned pixel data.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [15:0] pic_data,
  output logic [9:0]  pic_x,
  output logic [9:0]  pic_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned H_ACT_S = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_E = H_ACT_S + H_VALID;
  localparam int unsigned V_ACT_S = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_E = V_ACT_S + V_VALID;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_act;
  logic          v_act;
  logic          act;

  // Pixel and line counters; line counter advances on the last pixel of a line.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == CW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == CW'(V_TOTAL - 1)) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + CW'(1);
      end
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // Active-area decode and coordinate generation; all-ones marks blanking.
  always_comb begin
    h_act = (h_cnt >= CW'(H_ACT_S)) && (h_cnt < CW'(H_ACT_E));
    v_act = (v_cnt >= CW'(V_ACT_S)) && (v_cnt < CW'(V_ACT_E));
    act   = h_act && v_act;
    pic_x = '1;
    pic_y = '1;
    if (act) begin
      pic_x = h_cnt - CW'(H_ACT_S);
      pic_y = v_cnt - CW'(V_ACT_S);
    end
  end

  // Sync, valid and frame marker delayed one cycle to match pic_data latency.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~(h_cnt < CW'(H_SYNC));
      vsync       <= ~(v_cnt < CW'(V_SYNC));
      rgb_valid   <= act;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Blank the pixel bus outside active video.
  always_comb begin
    rgb = rgb_valid ? pic_data : 16'h0000;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: checks a full-size timing instance over the first active
// lines (twice, around a mid-line reset) and a shrunk instance over whole frames.
module tb_vga_timing_ctrl;

  typedef struct packed {
    int hs; int hb; int hv; int hf;
    int vs; int vb; int vv; int vf;
  } tim_t;

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic       hsy;
    logic       vsy;
    logic       rv;
    logic       fs;
  } exp_t;

  typedef struct packed {
    int         n;
    logic [9:0] px;
    logic [9:0] py;
    logic       hsy;
    logic       vsy;
    logic       rv;
    logic       fs;
  } vec_t;

  localparam tim_t TB = '{96, 48, 640, 16, 2, 33, 480, 10};
  localparam tim_t TS = '{4, 3, 8, 2, 2, 2, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_s;
  logic [15:0] pd, pd_s;
  logic [9:0]  pic_x, pic_y, pic_x_s, pic_y_s;
  logic        hsync, vsync, rgb_valid, frame_start;
  logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
  logic [15:0] rgb, rgb_s;

  int total = 0;
  int bad   = 0;
  int fs_cnt = 0;
  vec_t tbl[13];

  vga_timing_ctrl dut (
    .vga_clk(clk), .rst(rst), .pic_data(pd),
    .pic_x(pic_x), .pic_y(pic_y), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
  );

  vga_timing_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VALID(3), .V_FRONT(1)
  ) dut_s (
    .vga_clk(clk), .rst(rst_s), .pic_data(pd_s),
    .pic_x(pic_x_s), .pic_y(pic_y_s), .hsync(hsync_s), .vsync(vsync_s),
    .rgb_valid(rgb_valid_s), .rgb(rgb_s), .frame_start(frame_start_s)
  );

  function automatic logic in_act(input tim_t t, input int h, input int v);
    return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.hv) &&
           (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.vv);
  endfunction

  // Expected outputs n edges after reset release (n=0: in/just out of reset).
  function automatic exp_t model(input tim_t t, input int n);
    exp_t e;
    int ht, vt, h, v, hp, vp;
    ht = t.hs + t.hb + t.hv + t.hf;
    vt = t.vs + t.vb + t.vv + t.vf;
    h = n % ht;
    v = (n / ht) % vt;
    if (in_act(t, h, v)) begin
      e.px = 10'(h - t.hs - t.hb);
      e.py = 10'(v - t.vs - t.vb);
    end else begin
      e.px = 10'h3FF;
      e.py = 10'h3FF;
    end
    if (n == 0) begin
      e.hsy = 1'b1; e.vsy = 1'b1; e.rv = 1'b0; e.fs = 1'b0;
    end else begin
      hp = (n - 1) % ht;
      vp = ((n - 1) / ht) % vt;
      e.hsy = !(hp < t.hs);
      e.vsy = !(vp < t.vs);
      e.rv  = in_act(t, hp, vp);
      e.fs  = (hp == 0) && (vp == 0);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at n=%0d: got=%0h expected=%0h", nm, n, got, exp);
    end
  endtask

  // Run cycles on one instance, checking every cycle against the model.
  task automatic run(input bit sel, input int cycles, inout int n);
    exp_t e, ep;
    tim_t t;
    logic [9:0] cap;
    logic [15:0] d, rexp;
    int mode, ht;
    logic [9:0] apx, apy;
    logic ahs, avs, arv, afs;
    logic [15:0] argb;
    string tg;
    t  = sel ? TS : TB;
    tg = sel ? "s." : "b.";
    ht = t.hs + t.hb + t.hv + t.hf;
    mode = 0;
    for (int i = 0; i < cycles; i++) begin
      cap = sel ? pic_x_s : pic_x;
      @(posedge clk);
      #2;
      n++;
      if (i == 0 || (n % ht) == 1) mode = $urandom_range(0, 2);
      case (mode)
        0:       d = 16'hF800;
        1:       d = {6'b0, cap};
        default: d = 16'($urandom);
      endcase
      if (sel) pd_s = d; else pd = d;
      #1;
      if (sel) begin
        apx = pic_x_s; apy = pic_y_s; ahs = hsync_s; avs = vsync_s;
        arv = rgb_valid_s; afs = frame_start_s; argb = rgb_s;
      end else begin
        apx = pic_x; apy = pic_y; ahs = hsync; avs = vsync;
        arv = rgb_valid; afs = frame_start; argb = rgb;
      end
      e  = model(t, n);
      ep = model(t, n - 1);
      rexp = !e.rv ? 16'h0000 : (mode == 1 ? {6'b0, ep.px} : d);
      chk({tg, "pic_x"}, n, 32'(apx), 32'(e.px));
      chk({tg, "pic_y"}, n, 32'(apy), 32'(e.py));
      chk({tg, "hsync"}, n, 32'(ahs), 32'(e.hsy));
      chk({tg, "vsync"}, n, 32'(avs), 32'(e.vsy));
      chk({tg, "rgb_valid"}, n, 32'(arv), 32'(e.rv));
      chk({tg, "frame_start"}, n, 32'(afs), 32'(e.fs));
      chk({tg, "rgb"}, n, 32'(argb), 32'(rexp));
      if (sel && afs === 1'b1) fs_cnt++;
      if (!sel) begin
        for (int k = 0; k < 13; k++) begin
          if (tbl[k].n == n) begin
            chk("vec.pic_x", n, 32'(apx), 32'(tbl[k].px));
            chk("vec.pic_y", n, 32'(apy), 32'(tbl[k].py));
            chk("vec.hsync", n, 32'(ahs), 32'(tbl[k].hsy));
            chk("vec.vsync", n, 32'(avs), 32'(tbl[k].vsy));
            chk("vec.rgb_valid", n, 32'(arv), 32'(tbl[k].rv));
            chk("vec.frame_start", n, 32'(afs), 32'(tbl[k].fs));
          end
        end
      end
    end
  endtask

  // Asynchronous reset assertion mid-line: outputs must drop to idle without a clock edge.
  task automatic mid_reset(input bit sel, input string tg);
    #2;
    if (sel) begin rst_s = 1'b1; pd_s = 16'hF800; end
    else     begin rst = 1'b1;   pd = 16'hF800;   end
    #1;
    for (int r = 0; r < 2; r++) begin
      chk({tg, "rst.hsync"}, r, 32'(sel ? hsync_s : hsync), 32'd1);
      chk({tg, "rst.vsync"}, r, 32'(sel ? vsync_s : vsync), 32'd1);
      chk({tg, "rst.rgb_valid"}, r, 32'(sel ? rgb_valid_s : rgb_valid), 32'd0);
      chk({tg, "rst.rgb"}, r, 32'(sel ? rgb_s : rgb), 32'd0);
      chk({tg, "rst.frame_start"}, r, 32'(sel ? frame_start_s : frame_start), 32'd0);
      chk({tg, "rst.pic_x"}, r, 32'(sel ? pic_x_s : pic_x), 32'h3FF);
      chk({tg, "rst.pic_y"}, r, 32'(sel ? pic_y_s : pic_y), 32'h3FF);
      @(posedge clk);
      #2;
    end
    if (sel) rst_s = 1'b0; else rst = 1'b0;
  endtask

  initial begin
    int nb, ns;
    tbl[0]  = '{1,     10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{2,     10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{96,    10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{97,    10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1600,  10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1601,  10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{28144, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{28145, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{28783, 10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{28784, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{28785, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{28944, 10'd0,   10'd1,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{30000, 10'd256, 10'd2,   1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; rst_s = 1'b1;
    pd = 16'($urandom); pd_s = 16'($urandom);
    #7;
    chk("b.reset.hsync", 0, 32'(hsync), 32'd1);
    chk("b.reset.vsync", 0, 32'(vsync), 32'd1);
    chk("b.reset.rgb_valid", 0, 32'(rgb_valid), 32'd0);
    chk("b.reset.rgb", 0, 32'(rgb), 32'd0);
    chk("b.reset.frame_start", 0, 32'(frame_start), 32'd0);
    chk("b.reset.pic_x", 0, 32'(pic_x), 32'h3FF);
    chk("s.reset.rgb", 0, 32'(rgb_s), 32'd0);
    #10;
    rst = 1'b0; rst_s = 1'b0;
    nb = 0; ns = 0;
    fork
      begin
        run(1'b0, 31500, nb);
        mid_reset(1'b0, "b.");
        nb = 0;
        run(1'b0, 28800, nb);
      end
      begin
        fs_cnt = 0;
        run(1'b1, 564, ns);
        chk("s.frame_count", ns, 32'(fs_cnt), 32'd5);
        mid_reset(1'b1, "s.");
        ns = 0;
        fs_cnt = 0;
        run(1'b1, 300, ns);
        chk("s.frame_count_after_reset", ns, 32'(fs_cnt), 32'd3);
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
